// File: rtl/prog_clock_gen.sv
// rtl/prog_clock_gen.sv - N-channel programmable power-of-two clock divider
//
// Purpose:
//   Derives N_CH divided clocks from the system clock. Each channel has its own
//   half-period H(s) = BASE_HALF << s. A new selection is requested through a
//   valid/ready handshake. It is parked as "pending" and is only applied at a
//   falling toggle or while the channel sits stopped and low. This means no
//   output pulse is ever shortened. Per-channel enables stop an output only
//   after its current high phase completes.
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   asynchronous, active-high
//   en_i          in   [N_CH]        per-channel run enable
//   upd_valid_i   in                 rate-change request valid
//   upd_ch_i      in   [CH_W]        target channel of request
//   upd_sel_i     in   [SEL_W]       requested rate select
//   upd_ready_o   out                request accepted when valid & ready
//   clk_out_o     out  [N_CH]        divided clocks, straight from flops
//   pending_o     out  [N_CH]        accepted selection not yet applied
//   prog_out_o    out  [N_CH*SEL_W]  active selection, ch k at [k*SEL_W +: SEL_W]

module prog_clock_gen #(
    parameter int N_CH      = 2,
    parameter int CH_W      = 1,
    parameter int SEL_W     = 3,
    parameter int CNT_W     = 32,
    parameter int BASE_HALF = 5,
    parameter int RESET_SEL = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_CH-1:0]         en_i,
    input  logic                    upd_valid_i,
    input  logic [CH_W-1:0]         upd_ch_i,
    input  logic [SEL_W-1:0]        upd_sel_i,
    output logic                    upd_ready_o,
    output logic [N_CH-1:0]         clk_out_o,
    output logic [N_CH-1:0]         pending_o,
    output logic [N_CH*SEL_W-1:0]   prog_out_o
);

    // A channel can take a request only when it has nothing parked. Channel
    // indices at or above N_CH match no channel, so they are never ready.
    always_comb begin
        upd_ready_o = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (int'(upd_ch_i) == k) begin
                upd_ready_o = ~pending_o[k];
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] half_m1;
        logic [SEL_W-1:0] sel_q, sel_d;
        logic [SEL_W-1:0] pend_sel_q, pend_sel_d;
        logic             clk_q, clk_d;
        logic             pend_q, pend_d;
        logic             accept;
        logic             stopped;
        logic             at_terminal;
        logic             apply;

        assign half_m1 = (CNT_W'(BASE_HALF) << sel_q) - CNT_W'(1);

        always_comb begin
            cnt_d      = cnt_q;
            clk_d      = clk_q;
            sel_d      = sel_q;
            pend_sel_d = pend_sel_q;
            pend_d     = pend_q;

            accept      = upd_valid_i & upd_ready_o & (int'(upd_ch_i) == k);
            // A high output always finishes its phase, so only a low output
            // with its enable removed counts as stopped.
            stopped     = ~clk_q & ~en_i[k];
            at_terminal = (cnt_q == half_m1);
            // Only the stored pending flag is used here. A request accepted in
            // this same cycle therefore waits for the next apply point.
            apply       = pend_q & (stopped | (clk_q & at_terminal));

            if (stopped) begin
                cnt_d = '0;
            end else if (at_terminal) begin
                cnt_d = '0;
                clk_d = ~clk_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            if (apply) begin
                sel_d  = pend_sel_q;
                pend_d = 1'b0;
            end

            // accept requires pend_q==0, so it never collides with apply.
            if (accept) begin
                pend_sel_d = upd_sel_i;
                pend_d     = 1'b1;
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                cnt_q      <= '0;
                clk_q      <= 1'b0;
                sel_q      <= SEL_W'(RESET_SEL);
                pend_sel_q <= SEL_W'(RESET_SEL);
                pend_q     <= 1'b0;
            end else begin
                cnt_q      <= cnt_d;
                clk_q      <= clk_d;
                sel_q      <= sel_d;
                pend_sel_q <= pend_sel_d;
                pend_q     <= pend_d;
            end
        end

        assign clk_out_o[k]                  = clk_q;
        assign pending_o[k]                  = pend_q;
        assign prog_out_o[k*SEL_W +: SEL_W]  = sel_q;
    end

endmodule

// File: tb/tb_prog_clock_gen.sv
// tb/tb_prog_clock_gen.sv - directed vector bench for prog_clock_gen

module tb_prog_clock_gen;

    logic       clock;
    logic       reset;
    logic [1:0] en;
    logic       upd_valid;
    logic [1:0] upd_ch;
    logic [2:0] upd_sel;
    logic       upd_ready;
    logic [1:0] clk_out;
    logic [1:0] pending;
    logic [5:0] prog_out;

    prog_clock_gen #(
        .N_CH(2), .CH_W(2), .SEL_W(3), .CNT_W(32), .BASE_HALF(5), .RESET_SEL(0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .en_i        (en),
        .upd_valid_i (upd_valid),
        .upd_ch_i    (upd_ch),
        .upd_sel_i   (upd_sel),
        .upd_ready_o (upd_ready),
        .clk_out_o   (clk_out),
        .pending_o   (pending),
        .prog_out_o  (prog_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        int         edge_n;
        logic [1:0] en;
        logic       uv;
        logic [1:0] ch;
        logic [2:0] sel;
        logic       rdy;
        logic [1:0] clk;
        logic [1:0] pend;
        logic [5:0] prog;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   errors;
    int   ec;

    task automatic add(input int e, input logic [1:0] en_v, input logic uv,
                       input logic [1:0] ch, input logic [2:0] sel, input logic rdy,
                       input logic [1:0] clk, input logic [1:0] pend, input logic [5:0] prog);
        vec_t v;
        v = '{e, en_v, uv, ch, sel, rdy, clk, pend, prog};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ec);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        ec++;
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        ec     = 0;

        //   edge en     uv ch sel rdy clk    pend   prog
        add(  4, 2'b11, 0, 0, 0, 1, 2'b00, 2'b00, 6'o00);
        add(  5, 2'b11, 0, 0, 0, 1, 2'b11, 2'b00, 6'o00);
        add(  7, 2'b11, 1, 1, 2, 1, 2'b11, 2'b10, 6'o00);
        add(  8, 2'b11, 1, 1, 5, 0, 2'b11, 2'b10, 6'o00);
        add( 10, 2'b11, 0, 0, 0, 1, 2'b00, 2'b00, 6'o20);
        add( 15, 2'b11, 0, 0, 0, 1, 2'b01, 2'b00, 6'o20);
        add( 17, 2'b10, 0, 0, 0, 1, 2'b01, 2'b00, 6'o20);
        add( 19, 2'b10, 0, 0, 0, 1, 2'b01, 2'b00, 6'o20);
        add( 20, 2'b10, 0, 0, 0, 1, 2'b00, 2'b00, 6'o20);
        add( 25, 2'b10, 0, 0, 0, 1, 2'b00, 2'b00, 6'o20);
        add( 27, 2'b11, 0, 0, 0, 1, 2'b00, 2'b00, 6'o20);
        add( 30, 2'b11, 0, 0, 0, 1, 2'b10, 2'b00, 6'o20);
        add( 31, 2'b11, 0, 0, 0, 1, 2'b11, 2'b00, 6'o20);
        add( 36, 2'b11, 0, 0, 0, 1, 2'b10, 2'b00, 6'o20);
        add( 37, 2'b11, 1, 0, 1, 1, 2'b10, 2'b01, 6'o20);
        add( 38, 2'b11, 1, 0, 3, 0, 2'b10, 2'b01, 6'o20);
        add( 41, 2'b11, 0, 0, 0, 0, 2'b11, 2'b01, 6'o20);
        add( 46, 2'b11, 0, 0, 0, 0, 2'b10, 2'b00, 6'o21);
        add( 50, 2'b11, 0, 0, 0, 1, 2'b00, 2'b00, 6'o21);
        add( 52, 2'b11, 1, 2, 7, 0, 2'b00, 2'b00, 6'o21);
        add( 53, 2'b11, 1, 3, 7, 0, 2'b00, 2'b00, 6'o21);
        add( 56, 2'b11, 0, 0, 0, 1, 2'b01, 2'b00, 6'o21);
        add( 66, 2'b11, 1, 0, 0, 1, 2'b00, 2'b01, 6'o21);
        add( 70, 2'b11, 0, 0, 0, 0, 2'b10, 2'b01, 6'o21);
        add( 76, 2'b11, 0, 0, 0, 0, 2'b11, 2'b01, 6'o21);
        add( 86, 2'b11, 0, 0, 0, 0, 2'b10, 2'b00, 6'o20);
        add( 90, 2'b11, 0, 0, 0, 1, 2'b00, 2'b00, 6'o20);
        add( 91, 2'b11, 0, 0, 0, 1, 2'b01, 2'b00, 6'o20);
        add( 92, 2'b01, 0, 0, 0, 1, 2'b01, 2'b00, 6'o20);
        add( 93, 2'b01, 1, 1, 0, 1, 2'b01, 2'b10, 6'o20);
        add( 94, 2'b01, 0, 0, 0, 1, 2'b01, 2'b00, 6'o00);

        reset     = 1'b1;
        en        = 2'b11;
        upd_valid = 1'b0;
        upd_ch    = 2'd0;
        upd_sel   = 3'd0;
        repeat (3) @(negedge clock);
        check("reset_clk", 32'(clk_out), 32'h0);
        check("reset_pend", 32'(pending), 32'h0);
        check("reset_prog", 32'(prog_out), 32'h0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            while (ec < vecs[i].edge_n - 1) step();
            en        = vecs[i].en;
            upd_valid = vecs[i].uv;
            upd_ch    = vecs[i].ch;
            upd_sel   = vecs[i].sel;
            #1;
            check($sformatf("v%0d_ready", i), 32'(upd_ready), 32'(vecs[i].rdy));
            step();
            check($sformatf("v%0d_clk", i), 32'(clk_out), 32'(vecs[i].clk));
            check($sformatf("v%0d_pend", i), 32'(pending), 32'(vecs[i].pend));
            check($sformatf("v%0d_prog", i), 32'(prog_out), 32'(vecs[i].prog));
            upd_valid = 1'b0;
            upd_ch    = 2'd0;
            upd_sel   = 3'd0;
        end

        // ch1 stopped: sel=7 applies on the cycle after acceptance
        upd_valid = 1'b1;
        upd_ch    = 2'd1;
        upd_sel   = 3'd7;
        #1;
        check("sel7_ready", 32'(upd_ready), 32'h1);
        step();
        upd_valid = 1'b0;
        step();
        check("sel7_prog", 32'(prog_out), 32'o70);
        check("sel7_pend", 32'(pending), 32'h0);

        // 640-cycle half period: first rise on the 640th edge after enable
        en = 2'b11;
        n  = 0;
        do begin
            step();
            n++;
        end while (!clk_out[1] && n < 1000);
        check("h640_rise", 32'(n), 32'd640);

        upd_valid = 1'b1;
        upd_ch    = 2'd1;
        upd_sel   = 3'd7;
        #1;
        check("h640_req_ready", 32'(upd_ready), 32'h1);
        step();
        upd_valid = 1'b0;
        check("h640_pend", 32'(pending), 32'b10);
        check("h640_prog", 32'(prog_out[5:3]), 32'd7);
        step();
        step();
        check("h640_clk1_high", 32'(clk_out[1]), 32'h1);

        // async reset mid-cycle
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("async_clk", 32'(clk_out), 32'h0);
        check("async_pend", 32'(pending), 32'h0);
        check("async_prog", 32'(prog_out), 32'h0);
        @(negedge clock);
        en    = 2'b11;
        reset = 1'b0;
        ec    = 0;
        repeat (4) step();
        check("post_e4_clk", 32'(clk_out), 32'h0);
        step();
        check("post_e5_clk", 32'(clk_out), 32'b11);
        check("post_e5_prog", 32'(prog_out), 32'h0);
        repeat (5) step();
        check("post_e10_clk", 32'(clk_out), 32'h0);
        repeat (5) step();
        check("post_e15_clk", 32'(clk_out), 32'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
